dlx_alu: RTL and testbench
==========================

Name: dlx_alu

Overview:
- 32-bit integer ALU for the DLX execute stage, with an optional single-precision FP add and int/float conversion unit.
- Operands and opcode are sampled on the rising clock edge; the result and four flags are registered outputs with 1-cycle latency.
- Results feed the EX/MEM pipeline register and the branch/set logic.

Parameters:
- WIDTH, 32, datapath width. Fixed at 32; the FP unit requires 32.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- A  in  32  operand A (rs1)
- B  in  32  operand B (rs2/immediate); B[4:0] is the shift amount
- Op  in  5  operation select
- Result  out  32  registered result
- Carryout  out  1  carry out of bit 31 (ADD/SUB only)
- Overflow  out  1  signed overflow (ADD/SUB only)
- Zero  out  1  Result == 0
- Set  out  1  comparison/sign flag

Behaviour:
- Timing: one clock; reset is asynchronous and active-high.
  - On rst high, all outputs clear to 0 immediately, including Zero.
  - When rst deasserts, the next rising edge loads normally.
  - Each edge registers f(A,B,Op). There is no enable or handshake: new operands are accepted every cycle.
- Op encoding:
  - 00000 AND; 00001 OR; 00100 XOR.
  - 00010 ADD: A+B mod 2^32.
  - 00011 SUB: A+~B+1.
  - 00101 SLL: A<<B[4:0]; 00110 SRL: logical right; 01010 SRA: arithmetic right.
  - 00111 SLTU: unsigned A<B.
  - 01000 SLT: signed A<B.
  - 01001 SGE: signed A>=B.
  - 01011 SEQ: A==B; 01100 SNE: A!=B.
  - 01111 ADDF; 11110 CVTITF; 11111 CVTFTI. These three are gated by the optional feature.
  - Any other code: Result=0, Carryout/Overflow/Set=0, Zero=1.
- Set ops (SLTU..SNE): Result={31'b0,cond}; Set=cond; Carryout=Overflow=0.
- ADD/SUB flags:
  - Carryout = carry out of bit 31; for SUB, 1 means no borrow.
  - Overflow = operand signs agree (after B inversion for SUB) and result sign differs.
  - Set = Result[31] XOR Overflow, i.e. the true sign; on SUB this equals signed A<B.
- Logic and shift ops: Carryout=Overflow=Set=0.
- Zero = (Result==0) for every op, registered with Result.
- FP format: IEEE-754 single.
  - Denormal inputs are flushed to zero.
  - Rounding is truncation toward zero.
- ADDF:
  - Align by exponent difference; shifts of 25 or more leave the larger operand.
  - Add or subtract mantissas, then normalise.
  - Exact cancellation gives +0.
  - Exponent overflow gives a signed infinity; underflow gives signed zero.
  - A NaN operand, or inf + -inf, gives 0x7FC00000.
  - inf + finite gives that inf.
- CVTITF: signed 32-bit integer to float, truncated; 0 gives 0x00000000.
- CVTFTI: float to signed integer, truncated toward zero.
  - |x| >= 2^31 saturates to 0x7FFFFFFF or 0x80000000 by sign.
  - NaN gives 0x7FFFFFFF; |x|<1 gives 0.
- FP ops drive Carryout=Overflow=Set=0.
- Reset asserted mid-stream discards the in-flight result; outputs stay 0 while rst is high.

Optional Feature:
- Macro ALU_FPU_EN.
- Defined: ADDF, CVTITF and CVTFTI are implemented as above.
- Undefined: the FP logic is not synthesised; those three opcodes behave as unused codes (Result=0, Zero=1, other flags 0).

Test Plan:
- rst pulse mid-cycle -> all outputs 0 asynchronously. Then A=5, B=4, Op=SUB -> next edge: Result=1, Carryout=1, Overflow=0, Zero=0, Set=0.
- Adds:
  - ADD 100 + 0x7FFFFFFD -> 0x80000061, Overflow=1.
  - ADD 0xFFFFFFFF + 1 -> 0, Zero=1, Carryout=1.
  - ADD -45 + -20 -> 0xFFFFFFBF, Carryout=1, Overflow=0.
- Shifts and logic:
  - SLL 1023,2 -> 0x00000FFC; SRL 1023,2 -> 0x000000FF.
  - AND 7,5 -> 5; OR 1,4 -> 5; XOR 13,7 -> 10.
- Compares:
  - SLT -15,-7 -> Result=1, Set=1.
  - SLTU 1024,2133 -> 1.
  - SGE 3024,2133 -> 1.
  - SUB -5 - -70 -> 65, Set=0.
- With ALU_FPU_EN:
  - ADDF 0x41700000 + 0x43700000 -> 0x437F0000.
  - CVTITF 15 -> 0x41700000.
  - CVTFTI 0x4E7FFFFF -> 0x3FFFFFC0.
  - CVTFTI 0x4F000000 -> 0x7FFFFFFF.
- Without ALU_FPU_EN: Op=01111 -> Result=0, Zero=1.
- Back-to-back ops on consecutive edges -> each result appears exactly one cycle after its operands; unused Op 01110 -> Result=0, Zero=1.

Source files
------------

// File: rtl/dlx_alu.sv
// dlx_alu: 32-bit integer ALU for the DLX execute stage with registered outputs
// (one cycle of latency, a new operation accepted every cycle).
//
// Optional single-precision FP add and int/float conversions are built only when
// the macro ALU_FPU_EN is defined; otherwise their opcodes act as unused codes.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset (clears all outputs)
//   A, B      operands; B[4:0] is the shift amount
//   Op        5-bit operation select
//   Result    registered result
//   Carryout  carry out of bit 31 (ADD/SUB only)
//   Overflow  signed overflow (ADD/SUB only)
//   Zero      Result == 0
//   Set       comparison / true-sign flag
module dlx_alu #(
  parameter int unsigned WIDTH = 32  // fixed at 32; the FP unit depends on it
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Op,
  output logic [WIDTH-1:0] Result,
  output logic             Carryout,
  output logic             Overflow,
  output logic             Zero,
  output logic             Set
);

  localparam logic [4:0] OpAnd    = 5'b00000;
  localparam logic [4:0] OpOr     = 5'b00001;
  localparam logic [4:0] OpAdd    = 5'b00010;
  localparam logic [4:0] OpSub    = 5'b00011;
  localparam logic [4:0] OpXor    = 5'b00100;
  localparam logic [4:0] OpSll    = 5'b00101;
  localparam logic [4:0] OpSrl    = 5'b00110;
  localparam logic [4:0] OpSltu   = 5'b00111;
  localparam logic [4:0] OpSlt    = 5'b01000;
  localparam logic [4:0] OpSge    = 5'b01001;
  localparam logic [4:0] OpSra    = 5'b01010;
  localparam logic [4:0] OpSeq    = 5'b01011;
  localparam logic [4:0] OpSne    = 5'b01100;
`ifdef ALU_FPU_EN
  localparam logic [4:0] OpAddf   = 5'b01111;
  localparam logic [4:0] OpCvtitf = 5'b11110;
  localparam logic [4:0] OpCvtfti = 5'b11111;

  // FP add, truncating. Mantissas are held in a 50-bit window so an alignment
  // shift of up to 24 loses nothing and the final truncation is exact.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic        sa, sb, sl, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [7:0]  ea, eb, el, es, d;
    logic [23:0] ml, ms;
    logic [31:0] big;
    logic [49:0] wl, ws, wsum, norm;
    logic [5:0]  lead;
    int          exp_r;
    sa = a[31]; ea = a[30:23];
    sb = b[31]; eb = b[30:23];
    a_nan  = (ea == 8'hFF) && (a[22:0] != '0);
    b_nan  = (eb == 8'hFF) && (b[22:0] != '0);
    a_inf  = (ea == 8'hFF) && (a[22:0] == '0);
    b_inf  = (eb == 8'hFF) && (b[22:0] == '0);
    a_zero = (ea == 8'h00);  // denormals flush to zero
    b_zero = (eb == 8'h00);
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) return 32'h7FC0_0000;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {sa & sb, 31'b0};
    if (a_zero) return b;
    if (b_zero) return a;
    if (a[30:0] >= b[30:0]) begin
      big = a; sl = sa; el = ea; ml = {1'b1, a[22:0]}; es = eb; ms = {1'b1, b[22:0]};
    end else begin
      big = b; sl = sb; el = eb; ml = {1'b1, b[22:0]}; es = ea; ms = {1'b1, a[22:0]};
    end
    d = el - es;
    if (d >= 8'd25) return big;
    wl   = {1'b0, ml, 25'b0};
    ws   = {1'b0, ms, 25'b0} >> d;
    wsum = (sa != sb) ? (wl - ws) : (wl + ws);
    if (wsum == '0) return 32'h0000_0000;
    lead = '0;
    for (int i = 0; i < 50; i++) if (wsum[i]) lead = 6'(i);
    norm  = wsum << (6'd49 - lead);
    // Leading one of the larger operand sits at bit 48.
    exp_r = int'(el) + int'(lead) - 48;
    if (exp_r >= 255) return {sl, 8'hFF, 23'b0};
    if (exp_r <= 0) return {sl, 31'b0};
    return {sl, 8'(exp_r), 23'(norm >> 26)};
  endfunction

  function automatic logic [31:0] int_to_fp(input logic [31:0] x);
    logic [31:0] mag, norm;
    logic [4:0]  lead;
    if (x == '0) return 32'h0000_0000;
    mag  = x[31] ? (~x + 32'd1) : x;
    lead = '0;
    for (int i = 0; i < 32; i++) if (mag[i]) lead = 5'(i);
    norm = mag << (5'd31 - lead);
    return {x[31], 8'd127 + {3'b0, lead}, 23'(norm >> 8)};
  endfunction

  function automatic logic [31:0] fp_to_int(input logic [31:0] f);
    logic [7:0]  e;
    logic [31:0] mag;
    e = f[30:23];
    if ((e == 8'hFF) && (f[22:0] != '0)) return 32'h7FFF_FFFF;
    if (e < 8'd127) return 32'h0000_0000;
    if (e >= 8'd158) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (e >= 8'd150) mag = {8'b0, 1'b1, f[22:0]} << (e - 8'd150);
    else             mag = {8'b0, 1'b1, f[22:0]} >> (8'd150 - e);
    return f[31] ? (~mag + 32'd1) : mag;
  endfunction
`endif

  logic             is_sub, add_ovf, cond;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;

  // SUB is A + ~B + 1; carry out of 1 therefore means no borrow.
  assign is_sub   = (Op == OpSub);
  assign b_eff    = is_sub ? ~B : B;
  assign sum_full = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign add_ovf  = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum_full[WIDTH-1] != A[WIDTH-1]);

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q, ovf_d, ovf_q, zero_d, zero_q, set_d, set_q;

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    set_d    = 1'b0;
    cond     = 1'b0;
    case (Op)
      OpAnd: result_d = A & B;
      OpOr:  result_d = A | B;
      OpXor: result_d = A ^ B;
      OpAdd, OpSub: begin
        result_d = sum_full[WIDTH-1:0];
        carry_d  = sum_full[WIDTH];
        ovf_d    = add_ovf;
        set_d    = sum_full[WIDTH-1] ^ add_ovf;
      end
      OpSll: result_d = A << B[4:0];
      OpSrl: result_d = A >> B[4:0];
      OpSra: result_d = WIDTH'($signed(A) >>> B[4:0]);
      OpSltu, OpSlt, OpSge, OpSeq, OpSne: begin
        case (Op)
          OpSltu:  cond = (A < B);
          OpSlt:   cond = ($signed(A) < $signed(B));
          OpSge:   cond = ($signed(A) >= $signed(B));
          OpSeq:   cond = (A == B);
          default: cond = (A != B);
        endcase
        result_d = {{(WIDTH-1){1'b0}}, cond};
        set_d    = cond;
      end
`ifdef ALU_FPU_EN
      OpAddf:   result_d = fp_add(A, B);
      OpCvtitf: result_d = int_to_fp(A);
      OpCvtfti: result_d = fp_to_int(A);
`endif
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      set_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      set_q    <= set_d;
    end
  end

  assign Result   = result_q;
  assign Carryout = carry_q;
  assign Overflow = ovf_q;
  assign Zero     = zero_q;
  assign Set      = set_q;

endmodule

// File: tb/tb_dlx_alu.sv
// Directed self-checking bench for dlx_alu. Flags are compared as {c,o,z,s}.
module tb_dlx_alu;

  logic        clk, rst;
  logic [31:0] A, B;
  logic [4:0]  Op;
  logic [31:0] Result;
  logic        Carryout, Overflow, Zero, Set;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] res;
    logic [3:0]  fl;  // {carry, overflow, zero, set}
  } vec_t;

  dlx_alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .Op       (Op),
    .Result   (Result),
    .Carryout (Carryout),
    .Overflow (Overflow),
    .Zero     (Zero),
    .Set      (Set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    @(negedge clk);
    A = a; B = b; Op = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; A = 32'd7; B = 32'd9; Op = 5'b00010;
    #2;
    checks++;
    if ({Result, Carryout, Overflow, Zero, Set} !== 36'h0) begin
      errors++;
      $display("FAIL reset_initial: got %h %b, expected 0 0000", Result,
               {Carryout, Overflow, Zero, Set});
    end
    @(negedge clk);
    rst = 1'b0;
    drive(32'h8000_0000, 32'h8000_0000, 5'b00010);  // 0, carry and overflow set
    checks++;
    if ({Result, Carryout, Overflow, Zero, Set} !== {32'h0, 4'b1111}) begin
      errors++;
      $display("FAIL reset_preload: got %h %b, expected 00000000 1111", Result,
               {Carryout, Overflow, Zero, Set});
    end
    #2 rst = 1'b1;  // mid-cycle, asynchronous
    #1;
    checks++;
    if ({Result, Carryout, Overflow, Zero, Set} !== 36'h0) begin
      errors++;
      $display("FAIL reset_async: got %h %b, expected 0 0000", Result,
               {Carryout, Overflow, Zero, Set});
    end
    A = 32'd5; B = 32'd4; Op = 5'b00011;
    @(posedge clk);
    #1;
    checks++;
    if ({Result, Carryout, Overflow, Zero, Set} !== 36'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h %b, expected 0 0000", Result,
               {Carryout, Overflow, Zero, Set});
    end
    @(negedge clk);
    rst = 1'b0;
    drive(32'd5, 32'd4, 5'b00011);
    checks++;
    if ({Result, Carryout, Overflow, Zero, Set} !== {32'd1, 4'b1000}) begin
      errors++;
      $display("FAIL reset_first_sub: got %h %b, expected 00000001 1000", Result,
               {Carryout, Overflow, Zero, Set});
    end
  endtask

  task automatic test_add_sub();
    vec_t v [0:5];
    v = '{
      '{32'd100,        32'h7FFF_FFFD, 5'b00010, 32'h8000_0061, 4'b0100},
      '{32'hFFFF_FFFF,  32'd1,         5'b00010, 32'h0000_0000, 4'b1010},
      '{32'hFFFF_FFD3,  32'hFFFF_FFEC, 5'b00010, 32'hFFFF_FFBF, 4'b1001},
      '{32'hFFFF_FFFB,  32'hFFFF_FFBA, 5'b00011, 32'd65,        4'b1000},
      '{32'h8000_0000,  32'd1,         5'b00011, 32'h7FFF_FFFF, 4'b1101},
      '{32'd3,          32'd5,         5'b00011, 32'hFFFF_FFFE, 4'b0001}
    };
    for (int i = 0; i < 6; i++) begin
      drive(v[i].a, v[i].b, v[i].op);
      checks++;
      if ({Result, Carryout, Overflow, Zero, Set} !== {v[i].res, v[i].fl}) begin
        errors++;
        $display("FAIL add_sub[%0d]: got %h %b, expected %h %b", i, Result,
                 {Carryout, Overflow, Zero, Set}, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_logic_shift();
    vec_t v [0:7];
    v = '{
      '{32'd1023,       32'd2,  5'b00101, 32'h0000_0FFC, 4'b0000},
      '{32'd1023,       32'd2,  5'b00110, 32'h0000_00FF, 4'b0000},
      '{32'h8000_0000,  32'd4,  5'b01010, 32'hF800_0000, 4'b0000},
      '{32'd1,          32'd63, 5'b00101, 32'h8000_0000, 4'b0000},
      '{32'd7,          32'd5,  5'b00000, 32'd5,         4'b0000},
      '{32'd1,          32'd4,  5'b00001, 32'd5,         4'b0000},
      '{32'd13,         32'd7,  5'b00100, 32'd10,        4'b0000},
      '{32'hF0,         32'h0F, 5'b00000, 32'd0,         4'b0010}
    };
    for (int i = 0; i < 8; i++) begin
      drive(v[i].a, v[i].b, v[i].op);
      checks++;
      if ({Result, Carryout, Overflow, Zero, Set} !== {v[i].res, v[i].fl}) begin
        errors++;
        $display("FAIL logic_shift[%0d]: got %h %b, expected %h %b", i, Result,
                 {Carryout, Overflow, Zero, Set}, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_compare();
    vec_t v [0:7];
    v = '{
      '{32'hFFFF_FFF1, 32'hFFFF_FFF9, 5'b01000, 32'd1, 4'b0001},
      '{32'd1024,      32'd2133,      5'b00111, 32'd1, 4'b0001},
      '{32'd3024,      32'd2133,      5'b01001, 32'd1, 4'b0001},
      '{32'hFFFF_FFFF, 32'd1,         5'b00111, 32'd0, 4'b0010},
      '{32'hFFFF_FFFF, 32'd1,         5'b01000, 32'd1, 4'b0001},
      '{32'hFFFF_FFFF, 32'd0,         5'b01001, 32'd0, 4'b0010},
      '{32'd42,        32'd42,        5'b01011, 32'd1, 4'b0001},
      '{32'd42,        32'd42,        5'b01100, 32'd0, 4'b0010}
    };
    for (int i = 0; i < 8; i++) begin
      drive(v[i].a, v[i].b, v[i].op);
      checks++;
      if ({Result, Carryout, Overflow, Zero, Set} !== {v[i].res, v[i].fl}) begin
        errors++;
        $display("FAIL compare[%0d]: got %h %b, expected %h %b", i, Result,
                 {Carryout, Overflow, Zero, Set}, v[i].res, v[i].fl);
      end
    end
  endtask

  task automatic test_fpu();
`ifdef ALU_FPU_EN
    vec_t v [0:7];
    v = '{
      '{32'h4170_0000, 32'h4370_0000, 5'b01111, 32'h437F_0000, 4'b0000},
      '{32'h3F80_0000, 32'hBF80_0000, 5'b01111, 32'h0000_0000, 4'b0010},
      '{32'h7F80_0001, 32'h3F80_0000, 5'b01111, 32'h7FC0_0000, 4'b0000},
      '{32'd15,        32'd0,         5'b11110, 32'h4170_0000, 4'b0000},
      '{32'hFFFF_FFFF, 32'd0,         5'b11110, 32'hBF80_0000, 4'b0000},
      '{32'h4E7F_FFFF, 32'd0,         5'b11111, 32'h3FFF_FFC0, 4'b0000},
      '{32'h4F00_0000, 32'd0,         5'b11111, 32'h7FFF_FFFF, 4'b0000},
      '{32'hC040_0000, 32'd0,         5'b11111, 32'hFFFF_FFFD, 4'b0000}
    };
`else
    vec_t v [0:7];
    v = '{
      '{32'h4170_0000, 32'h4370_0000, 5'b01111, 32'd0, 4'b0010},
      '{32'd15,        32'd0,         5'b11110, 32'd0, 4'b0010},
      '{32'h4E7F_FFFF, 32'd0,         5'b11111, 32'd0, 4'b0010},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b01111, 32'd0, 4'b0010},
      '{32'h4F00_0000, 32'd0,         5'b11111, 32'd0, 4'b0010},
      '{32'hFFFF_FFFF, 32'd0,         5'b11110, 32'd0, 4'b0010},
      '{32'hFFFF_FFFF, 32'd1,         5'b01101, 32'd0, 4'b0010},
      '{32'hFFFF_FFFF, 32'd1,         5'b10000, 32'd0, 4'b0010}
    };
`endif
    for (int i = 0; i < 8; i++) begin
      drive(v[i].a, v[i].b, v[i].op);
      checks++;
      if ({Result, Carryout, Overflow, Zero, Set} !== {v[i].res, v[i].fl}) begin
        errors++;
        $display("FAIL fpu[%0d]: got %h %b, expected %h %b", i, Result,
                 {Carryout, Overflow, Zero, Set}, v[i].res, v[i].fl);
      end
    end
  endtask

  // Operands change every cycle; each result must appear after exactly one edge
  // and must still be visible after the next operands are driven.
  task automatic test_back_to_back();
    vec_t v [0:4];
    v = '{
      '{32'd1,   32'd2,    5'b00010, 32'd3,         4'b0000},
      '{32'd9,   32'd9,    5'b01110, 32'd0,         4'b0010},
      '{32'hFF,  32'h0F,   5'b00100, 32'hF0,        4'b0000},
      '{32'd3,   32'd5,    5'b00011, 32'hFFFF_FFFE, 4'b0001},
      '{32'd0,   32'd0,    5'b00001, 32'd0,         4'b0010}
    };
    @(negedge clk);
    A = v[0].a; B = v[0].b; Op = v[0].op;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({Result, Carryout, Overflow, Zero, Set} !== {v[i].res, v[i].fl}) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h %b, expected %h %b", i, Result,
                 {Carryout, Overflow, Zero, Set}, v[i].res, v[i].fl);
      end
      @(negedge clk);
      if (i < 4) begin
        A = v[i+1].a; B = v[i+1].b; Op = v[i+1].op;
        #1;
        checks++;
        if (Result !== v[i].res) begin
          errors++;
          $display("FAIL back_to_back_hold[%0d]: got %h, expected %h", i, Result, v[i].res);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_compare();
    test_fpu();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
